// File: rtl/axi_pkg.sv
// Shared types for the single-beat AXI subordinate.
//   resp_t      : AXI response codes used by this responder
//   CH_*        : bit positions in tx_en / sub_new_data
//   wr_state_t  : write-channel FSM states
//   rd_state_t  : read-channel FSM states
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam int CH_AW = 4;
  localparam int CH_W  = 3;
  localparam int CH_B  = 2;
  localparam int CH_AR = 1;
  localparam int CH_R  = 0;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/sub_word_mem.sv
// Backing word memory for axi_sub_responder.
// One write port, one registered read port, synchronous clear.
//   clk      in   clock
//   rst      in   synchronous active-high clear (memory and read register)
//   wr_en    in   write strobe
//   wr_idx   in   write word index
//   wr_data  in   write word
//   rd_en    in   read strobe; rd_data updates on the next edge, holds otherwise
//   rd_idx   in   read word index
//   rd_data  out  registered read word
module sub_word_mem #(
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]            rd_data
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem_d [MEM_DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Read samples mem_q, so a same-edge write to the same index returns the old word.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
    rd_data_d = rd_en ? mem_q[rd_idx] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q     <= '{default: '0};
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_sub_responder.sv
// Single-beat AXI subordinate: accepts AW/W/AR, writes/reads a local word
// memory, returns B/R, and mirrors every accepted address/data to sub_rx_*.
//   ACLK, ARESET              clock, synchronous active-high reset
//   AW*/W*/B*/AR*/R*          AXI channels (single beat, no IDs/strobes)
//   tx_en[4:0]                per-channel handshake enable {AW,W,B,AR,R}
//   sub_rx_AW/W/AR            last accepted AWADDR / WDATA / ARADDR
//   sub_new_data[4:0]         one-cycle pulse after each channel handshake
//
// Write FSM
//   state   | meaning
//   WR_IDLE | collecting AW and W independently (aw_held/w_held)
//   WR_RESP | memory written, BVALID high until B handshake
// Read FSM
//   state   | meaning
//   RD_IDLE | ARREADY follows tx_en[AR]
//   RD_DATA | RDATA/RRESP held, RVALID high until R handshake
module axi_sub_responder
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic [4:0]        tx_en,
  output logic [ADDR_W-1:0] sub_rx_AW,
  output logic [DATA_W-1:0] sub_rx_W,
  output logic [ADDR_W-1:0] sub_rx_AR,
  output logic [4:0]        sub_new_data
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int HI    = OFF_W + IDX_W;

  wr_state_t         wr_state_q, wr_state_d;
  rd_state_t         rd_state_q, rd_state_d;
  logic              aw_held_q, aw_held_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic              aw_err_q, aw_err_d;
  logic              w_held_q, w_held_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  resp_t             bresp_q, bresp_d;
  resp_t             rresp_q, rresp_d;
  logic [ADDR_W-1:0] sub_rx_aw_q, sub_rx_aw_d;
  logic [DATA_W-1:0] sub_rx_w_q, sub_rx_w_d;
  logic [ADDR_W-1:0] sub_rx_ar_q, sub_rx_ar_d;
  logic [4:0]        new_data_q, new_data_d;

  logic              aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic              aw_err_in, ar_err_in;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_err;
  logic [DATA_W-1:0] wr_data;
  logic              both_held;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_rdata;

  assign aw_err_in = |AWADDR[ADDR_W-1:HI];
  assign ar_err_in = |ARADDR[ADDR_W-1:HI];

  assign aw_fire = AWVALID & AWREADY;
  assign w_fire  = WVALID & WREADY;
  assign b_fire  = BVALID & BREADY & tx_en[CH_B];
  assign ar_fire = ARVALID & ARREADY;
  assign r_fire  = RVALID & RREADY & tx_en[CH_R];

  // A beat arriving this cycle is used directly, so AW+W in cycle N gives BVALID in N+1.
  assign wr_idx    = aw_held_q ? aw_idx_q : AWADDR[OFF_W +: IDX_W];
  assign wr_err    = aw_held_q ? aw_err_q : aw_err_in;
  assign wr_data   = w_held_q  ? w_data_q : WDATA;
  assign both_held = (aw_held_q | aw_fire) & (w_held_q | w_fire);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q  <= WR_IDLE;
      rd_state_q  <= RD_IDLE;
      aw_held_q   <= 1'b0;
      aw_idx_q    <= '0;
      aw_err_q    <= 1'b0;
      w_held_q    <= 1'b0;
      w_data_q    <= '0;
      bresp_q     <= OKAY;
      rresp_q     <= OKAY;
      sub_rx_aw_q <= '0;
      sub_rx_w_q  <= '0;
      sub_rx_ar_q <= '0;
      new_data_q  <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      aw_held_q   <= aw_held_d;
      aw_idx_q    <= aw_idx_d;
      aw_err_q    <= aw_err_d;
      w_held_q    <= w_held_d;
      w_data_q    <= w_data_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      sub_rx_aw_q <= sub_rx_aw_d;
      sub_rx_w_q  <= sub_rx_w_d;
      sub_rx_ar_q <= sub_rx_ar_d;
      new_data_q  <= new_data_d;
    end
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    rd_state_d  = rd_state_q;
    aw_held_d   = aw_held_q;
    aw_idx_d    = aw_idx_q;
    aw_err_d    = aw_err_q;
    w_held_d    = w_held_q;
    w_data_d    = w_data_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;

    case (wr_state_q)
      WR_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          aw_idx_d  = AWADDR[OFF_W +: IDX_W];
          aw_err_d  = aw_err_in;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          w_data_d = WDATA;
        end
        if (both_held) begin
          wr_state_d = WR_RESP;
          bresp_d    = wr_err ? SLVERR : OKAY;
        end
      end
      WR_RESP: begin
        if (b_fire) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    case (rd_state_q)
      RD_IDLE: begin
        if (ar_fire) begin
          rd_state_d = RD_DATA;
          rresp_d    = ar_err_in ? SLVERR : OKAY;
        end
      end
      RD_DATA: begin
        if (r_fire) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase

    sub_rx_aw_d = aw_fire ? AWADDR : sub_rx_aw_q;
    sub_rx_w_d  = w_fire  ? WDATA  : sub_rx_w_q;
    sub_rx_ar_d = ar_fire ? ARADDR : sub_rx_ar_q;
    new_data_d  = {aw_fire, w_fire, b_fire, ar_fire, r_fire};
  end

  // READYs are forced low while ARESET is asserted so nothing is accepted during reset.
  always_comb begin
    AWREADY   = !ARESET && (wr_state_q == WR_IDLE) && tx_en[CH_AW] && !aw_held_q;
    WREADY    = !ARESET && (wr_state_q == WR_IDLE) && tx_en[CH_W]  && !w_held_q;
    BVALID    = (wr_state_q == WR_RESP);
    BRESP     = bresp_q;
    ARREADY   = !ARESET && (rd_state_q == RD_IDLE) && tx_en[CH_AR];
    RVALID    = (rd_state_q == RD_DATA);
    RRESP     = rresp_q;
    RDATA     = (rresp_q == SLVERR) ? '0 : mem_rdata;
    mem_wr_en = (wr_state_q == WR_IDLE) && both_held && !wr_err;
  end

  assign sub_rx_AW    = sub_rx_aw_q;
  assign sub_rx_W     = sub_rx_w_q;
  assign sub_rx_AR    = sub_rx_ar_q;
  assign sub_new_data = new_data_q;

  sub_word_mem #(
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk    (ACLK),
    .rst    (ARESET),
    .wr_en  (mem_wr_en),
    .wr_idx (wr_idx),
    .wr_data(wr_data),
    .rd_en  (ar_fire),
    .rd_idx (ARADDR[OFF_W +: IDX_W]),
    .rd_data(mem_rdata)
  );

endmodule

// File: tb/tb_axi_sub_responder.sv
module tb_axi_sub_responder;
  import axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [4:0]  tx_en;
  logic [31:0] sub_rx_AW;
  logic [63:0] sub_rx_W;
  logic [31:0] sub_rx_AR;
  logic [4:0]  sub_new_data;

  int checks = 0;
  int errors = 0;

  logic [1:0]  b_q[$];
  logic [63:0] rd_q[$];
  logic [1:0]  rr_q[$];

  always #5 ACLK = ~ACLK;

  axi_sub_responder #(.ADDR_W(32), .DATA_W(64), .MEM_DEPTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .tx_en(tx_en),
    .sub_rx_AW(sub_rx_AW), .sub_rx_W(sub_rx_W), .sub_rx_AR(sub_rx_AR),
    .sub_new_data(sub_new_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard monitor: compares every accepted B/R beat against the queued expectation.
  always @(negedge ACLK) begin : monitor
    logic [1:0]  eb;
    logic [63:0] ed;
    logic [1:0]  er;
    if (!ARESET && BVALID && BREADY && tx_en[CH_B]) begin
      if (b_q.size() == 0) chk("b_unexpected", 64'(BVALID), 64'd0);
      else begin
        eb = b_q.pop_front();
        chk("bresp", 64'(BRESP), 64'(eb));
      end
    end
    if (!ARESET && RVALID && RREADY && tx_en[CH_R]) begin
      if (rd_q.size() == 0) chk("r_unexpected", 64'(RVALID), 64'd0);
      else begin
        ed = rd_q.pop_front();
        er = rr_q.pop_front();
        chk("rdata", RDATA, ed);
        chk("rresp", 64'(RRESP), 64'(er));
      end
    end
  end

  task automatic wait_b();
    int n = 0;
    while (b_q.size() != 0 && n < 30) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    if (b_q.size() != 0) begin
      chk("b_timeout", 64'(b_q.size()), 64'd0);
      b_q.delete();
    end
    tick();
  endtask

  task automatic wait_r();
    int n = 0;
    while (rd_q.size() != 0 && n < 30) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    if (rd_q.size() != 0) begin
      chk("r_timeout", 64'(rd_q.size()), 64'd0);
      rd_q.delete();
      rr_q.delete();
    end
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [1:0] er);
    bit aw_done;
    bit w_done;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    b_q.push_back(er);
    AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 30) begin
      @(negedge ACLK);
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      tick();
      if (aw_done) AWVALID = 1'b0;
      if (w_done) WVALID = 1'b0;
      n++;
    end
    if (!(aw_done && w_done)) begin
      chk("wr_handshake_timeout", {62'd0, aw_done, w_done}, 64'd3);
      AWVALID = 1'b0; WVALID = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [63:0] d, input logic [1:0] er);
    bit done;
    int n;
    done = 0; n = 0;
    rd_q.push_back(d); rr_q.push_back(er);
    ARADDR = a; ARVALID = 1'b1;
    while (!done && n < 30) begin
      @(negedge ACLK);
      if (ARREADY) done = 1;
      tick();
      n++;
    end
    ARVALID = 1'b0;
    if (!done) chk("ar_timeout", 64'd0, 64'd1);
    @(negedge ACLK);
    chk("r_latency", 64'(RVALID), 64'd1);
    chk("sub_rx_ar", 64'(sub_rx_AR), 64'(a));
    #1;
    wait_r();
    @(negedge ACLK);
    chk("r_pulse", 64'(sub_new_data), 64'b00001);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready_valid"}, {59'd0, AWREADY, WREADY, ARREADY, BVALID, RVALID}, 64'd0);
    chk({tag, "_resp"}, {60'd0, BRESP, RRESP}, 64'd0);
    chk({tag, "_rdata"}, RDATA, 64'd0);
    chk({tag, "_sub_rx"}, {sub_rx_AW, sub_rx_AR} | sub_rx_W, 64'd0);
    chk({tag, "_new_data"}, 64'(sub_new_data), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    ARESET = 1'b1; tx_en = 5'h1F; BREADY = 1'b1; RREADY = 1'b1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    AWADDR = '0; WDATA = '0; ARADDR = '0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk_reset_outputs("reset");
    tick();
    ARESET = 1'b0;

    // AW and W in the same cycle
    tick();
    b_q.push_back(OKAY);
    AWADDR = 32'h08; WDATA = 64'hDEADBEEF_CAFEF00D; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    chk("aw_w_ready", {62'd0, AWREADY, WREADY}, 64'd3);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    chk("b_latency", 64'(BVALID), 64'd1);
    chk("aw_w_pulse", 64'(sub_new_data), 64'b11000);
    chk("sub_rx_w", sub_rx_W, 64'hDEADBEEF_CAFEF00D);
    chk("sub_rx_aw", 64'(sub_rx_AW), 64'h08);
    #1;
    wait_b();
    @(negedge ACLK);
    chk("b_pulse", 64'(sub_new_data), 64'b00100);
    chk("bvalid_cleared", 64'(BVALID), 64'd0);
    tick();
    rd(32'h08, 64'hDEADBEEF_CAFEF00D, OKAY);

    // W before AW
    b_q.push_back(OKAY);
    WDATA = 64'h11; WVALID = 1'b1;
    @(negedge ACLK);
    chk("w_first_ready", 64'(WREADY), 64'd1);
    tick();
    WVALID = 1'b0;
    @(negedge ACLK);
    chk("w_only_pulse", 64'(sub_new_data), 64'b01000);
    repeat (2) begin
      @(negedge ACLK);
      chk("w_held_ready", {62'd0, WREADY, BVALID}, 64'd0);
    end
    tick();
    AWADDR = 32'h10; AWVALID = 1'b1;
    @(negedge ACLK);
    chk("aw_late_ready", 64'(AWREADY), 64'd1);
    tick();
    AWVALID = 1'b0;
    @(negedge ACLK);
    chk("b_after_aw", 64'(BVALID), 64'd1);
    #1;
    wait_b();
    rd(32'h10, 64'h11, OKAY);

    // Out of range: index 0 must stay unwritten
    wr(32'h80, 64'h55, SLVERR);
    wait_b();
    rd(32'h80, 64'h0, SLVERR);
    rd(32'h00, 64'h0, OKAY);

    // B backpressure with a SLVERR response held
    BREADY = 1'b0;
    wr(32'h100, 64'h77, SLVERR);
    repeat (5) begin
      @(negedge ACLK);
      chk("b_stall", {61'd0, BVALID, BRESP}, {61'd0, 1'b1, 2'b10});
      chk("b_stall_awready", 64'(AWREADY), 64'd0);
    end
    tick();
    BREADY = 1'b1;
    wait_b();

    // AR disabled by tx_en
    tx_en = 5'b11101;
    rd_q.push_back(64'hDEADBEEF_CAFEF00D); rr_q.push_back(OKAY);
    ARADDR = 32'h08; ARVALID = 1'b1;
    repeat (4) begin
      @(negedge ACLK);
      chk("ar_disabled", {62'd0, ARREADY, RVALID}, 64'd0);
    end
    tick();
    tx_en = 5'h1F;
    @(negedge ACLK);
    chk("ar_enabled", 64'(ARREADY), 64'd1);
    tick();
    ARVALID = 1'b0;
    wait_r();

    // Same-edge read/write collision at index 2
    wr(32'h10, 64'hA, OKAY);
    wait_b();
    b_q.push_back(OKAY);
    rd_q.push_back(64'hA); rr_q.push_back(OKAY);
    AWADDR = 32'h10; WDATA = 64'hB; ARADDR = 32'h10;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(negedge ACLK);
    chk("collide_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    wait_b();
    wait_r();
    rd(32'h10, 64'hB, OKAY);

    // Reset between AW and W
    AWADDR = 32'h20; AWVALID = 1'b1;
    @(negedge ACLK);
    tick();
    AWVALID = 1'b0;
    @(negedge ACLK);
    chk("aw_held_mid", 64'(AWREADY), 64'd0);
    tick();
    ARESET = 1'b1;
    tick();
    @(negedge ACLK);
    chk_reset_outputs("midreset");
    tick();
    ARESET = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      chk("post_reset_idle", {62'd0, BVALID, AWREADY}, 64'd1);
    end
    tick();
    rd(32'h08, 64'h0, OKAY);
    wr(32'h20, 64'h99, OKAY);
    wait_b();
    rd(32'h20, 64'h99, OKAY);

    repeat (3) tick();
    chk("queues_drained", 64'(b_q.size() + rd_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
